// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// fetch_ok() applies the FETCH_BOUNDS_CHECK_EN address rules.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic fetch_ok(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order {pc, inst} buffer between fetch and decode.
// Flush wins over push/pop; push and pop together at full is legal.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_data,
    output logic [1:0]   count
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   base;
    logic         pop_ok;
    logic         push_ok;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q < 2'd2) || pop_ok);
        base    = pop_ok ? cnt_q - 2'd1 : cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_ok) begin
                e0_d = e1_q;
            end
            if (push_ok) begin
                if (base == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
            end
            cnt_d = push_ok ? base + 2'd1 : base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_data = e0_q;
    assign count     = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: pc sequencing, redirects, decode handshake.
// Define FETCH_BOUNDS_CHECK_EN to fault on misaligned/out-of-range fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    output logic        fetch_fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_ok;
    logic         tgt_ok;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t new_entry;

    assign pc_ok  = !BOUNDS_EN || fetch_ok(pc_q, MEM_DEPTH);
    assign tgt_ok = !BOUNDS_EN || fetch_ok(redirect_pc, MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect_valid) begin
                    state_d = tgt_ok ? ST_RUN : ST_FAULT;
                end else if (!pc_ok) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (redirect_valid && tgt_ok) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A redirect steals the cycle: no push, and the flush drops everything
    // except an entry popped in that same cycle.
    always_comb begin
        pop  = (count != 2'd0) && id_ready;
        push = (state_q == ST_RUN) && pc_ok && !redirect_valid
            && ((count < 2'd2) || pop);
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + INST_BYTES;
        end
        new_entry.pc   = pc_q;
        new_entry.inst = imem_inst;
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (new_entry),
        .head_data (head),
        .count     (count)
    );

    always_comb begin
        imem_pc  = pc_q;
        if_valid = (count != 2'd0);
        if_pc    = if_valid ? head.pc : 32'h0;
        if_inst  = if_valid ? head.inst : NOP_INST;
`ifdef FETCH_BOUNDS_CHECK_EN
        fetch_fault = (state_q == ST_FAULT);
`else
        fetch_fault = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scoreboard of expected transfers
// plus cycle-exact checks on startup, stall, redirect, reset and bounds.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    // memory word k holds k
    assign imem_inst = {2'b00, imem_pc[31:2]};

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_DEPTH (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .id_ready       (id_ready),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_load(input logic [31:0] start, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(start + 32'(4 * i));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                chk("xfer_unexp", {31'd0, if_valid}, 32'd0);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("xfer_pc", if_pc, e);
                chk("xfer_inst", if_inst, e >> 2);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(3);

        // startup and stall
        rst = 1'b0;
        sb_load(32'h0, 80);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        chk("rst_imem", imem_pc, 32'h0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        chk("c1_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("c2_valid", {31'd0, if_valid}, 32'd1);
        chk("c2_pc", if_pc, 32'h0);
        tick(4);
        chk("c6_pc", if_pc, 32'h10);
        chk("c6_imem", imem_pc, 32'h14);
        id_ready = 1'b0;
        tick(4);
        chk("stall_valid", {31'd0, if_valid}, 32'd1);
        chk("stall_pc", if_pc, 32'h10);
        chk("stall_hold", imem_pc, 32'h18);
        tick();
        id_ready = 1'b1;
        tick(3);

        // redirect with a full buffer and a pop in the same cycle
        id_ready = 1'b0;
        tick(3);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h34;
        tick();
        redirect_valid = 1'b0;
        sb_load(32'h34, 20);
        chk("rd_bubble", {31'd0, if_valid}, 32'd0);
        chk("rd_imem", imem_pc, 32'h34);
        tick();
        chk("rd_valid", {31'd0, if_valid}, 32'd1);
        chk("rd_pc", if_pc, 32'h34);
        chk("rd_inst", if_inst, 32'd13);
        tick(3);

        // reset with a full buffer and a pending redirect
        id_ready = 1'b0;
        tick(3);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        sb_q.delete();
        chk("mr_valid", {31'd0, if_valid}, 32'd0);
        chk("mr_inst", if_inst, 32'h0000_0013);
        chk("mr_imem", imem_pc, 32'h0);
        chk("mr_fault", {31'd0, fetch_fault}, 32'd0);

        // sequential run up to the end of memory
        rst            = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        sb_load(32'h0, 80);
        tick(2);
        chk("r2_pc", if_pc, 32'h0);
        tick(63);
        chk("r65_pc", if_pc, 32'hFC);
        chk("r65_imem", imem_pc, 32'h100);
        chk("r65_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        chk("r66_fault", {31'd0, fetch_fault}, {31'd0, BCHK});
        chk("r66_valid", {31'd0, if_valid}, {31'd0, !BCHK});
        chk("r66_pc", if_pc, BCHK ? 32'h0 : 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        sb_load(32'h0, 20);
        chk("rec_fault", {31'd0, fetch_fault}, 32'd0);
        tick();
        chk("rec_valid", {31'd0, if_valid}, 32'd1);
        chk("rec_pc", if_pc, 32'h0);
        tick(2);

        // misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        if (BCHK) sb_q.delete();
        else sb_load(32'h6, 10);
        chk("mis_fault", {31'd0, fetch_fault}, {31'd0, BCHK});
        chk("mis_bubble", {31'd0, if_valid}, 32'd0);
        chk("mis_imem", imem_pc, 32'h6);
        tick();
        chk("mis_valid", {31'd0, if_valid}, {31'd0, !BCHK});
        chk("mis_pc", if_pc, BCHK ? 32'h0 : 32'h6);
        chk("mis_fault2", {31'd0, fetch_fault}, {31'd0, BCHK});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        sb_load(32'h0, 20);
        tick();
        chk("mis_rec_pc", if_pc, 32'h0);
        chk("mis_rec_fault", {31'd0, fetch_fault}, 32'd0);
        tick(2);

        // pc wraparound without bounds checking
        if (!BCHK) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'hFFFF_FFF8;
            tick();
            redirect_valid = 1'b0;
            sb_load(32'hFFFF_FFF8, 10);
            tick();
            chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
            tick(2);
            chk("wrap_pc2", if_pc, 32'h0);
            chk("wrap_imem", imem_pc, 32'h4);
        end
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter MEM_DEPTH, default 64, instruction memory depth in 32-bit words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_pc  out  32  byte address driven to combinational instruction memory.
REQ-006 imem_inst  in  32  instruction word returned for imem_pc in the same cycle.
REQ-007 redirect_valid  in  1  branch/jump/flush request from execute.
REQ-008 redirect_pc  in  32  target byte address for a redirect.
REQ-009 if_valid  out  1  if_pc/if_inst hold a valid instruction for decode.
REQ-010 if_pc  out  32  byte address of the presented instruction.
REQ-011 if_inst  out  32  presented instruction word.
REQ-012 id_ready  in  1  decode accepts; transfer occurs when if_valid && id_ready.
REQ-013 fetch_fault  out  1  fetch address is invalid; fetch suspended.

Function
REQ-014 FSM states: IDLE, RUN, FAULT.
REQ-015 Transitions: IDLE->RUN unconditionally after one cycle; RUN->FAULT on an invalid fetch address (REQ-027); FAULT->RUN only on redirect_valid with a valid target; any state ->IDLE on rst.
REQ-016 pc register drives imem_pc directly.
REQ-017 2-entry in-order buffer of {pc, inst}; if_* presents the head entry; if_valid = buffer non-empty.
REQ-018 Push in RUN when (count<2 || pop) and !redirect_valid; push captures {pc, imem_inst}; pc <= pc+4 on push.
REQ-019 Pop when if_valid && id_ready; simultaneous push and pop at count 2 is legal; count stays 2.
REQ-020 Latency: an instruction pushed in cycle N appears on if_* in cycle N+1 (when it is the head entry).
REQ-021 Redirect has priority over push/pop: buffer flushed, pc <= redirect_pc, no push that cycle; if_valid=0 the next cycle; the first target instruction is presented 2 cycles after the redirect.
REQ-022 Redirect while a pop is in progress: the popped entry counts as transferred; all other entries are discarded.
REQ-023 With id_ready held low, fetch stops once count=2; pc holds; if_* stable until the pop.
REQ-024 pc arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-025 On rst: pc=RESET_PC, buffer empty, state IDLE; if_valid=0, if_pc=0, if_inst=32'h0000_0013 (NOP), fetch_fault=0; imem_pc=RESET_PC.
REQ-026 rst mid-operation discards buffered entries and any pending redirect in that cycle.

Configuration
REQ-027 With FETCH_BOUNDS_CHECK_EN defined: an address is invalid if pc[1:0]!=0 or (pc>>2)>=MEM_DEPTH. In RUN, an invalid pc causes no push, state->FAULT, fetch_fault=1 from the next cycle. Already-buffered entries still drain. A redirect to an invalid target enters FAULT directly.
REQ-028 Without FETCH_BOUNDS_CHECK_EN: no checks; fetch_fault is tied to 0; FAULT is unreachable; pc increments without limit.

Structure
REQ-029 Shared package (fetch_pkg) holds the state enum, NOP_INST=32'h0000_0013, and INST_BYTES=4.
REQ-030 The buffer is sub-module fetch_buf: 2-entry, 64-bit wide, with push/pop/flush inputs and count output.

Verification
REQ-031 Reset release, id_ready=1, memory word k = k: if_valid first high in cycle 2 with if_pc=0, then if_pc=4,8,... one per cycle.
REQ-032 id_ready=0 for 5 cycles from steady state: buffer fills to 2 and pc holds; on release, if_pc continues in sequence with no skipped or duplicated address.
REQ-033 redirect_valid with redirect_pc=32'h34 while count=2: if_valid=0 the next cycle; the cycle after shows if_pc=32'h34 with if_inst=mem[13].
REQ-034 Bounds check enabled, MEM_DEPTH=64: sequential fetch reaches pc=32'h100; fetch_fault=1 after 32'hFC is pushed; a redirect to 32'h0 resumes with if_pc=0.
REQ-035 Bounds check enabled: redirect to 32'h6 gives fetch_fault=1 and no push. Bounds check disabled: same stimulus gives fetch_fault=0 and a push at 32'h6.
REQ-036 rst asserted while count=2: the next cycle shows if_valid=0, if_inst=NOP, imem_pc=RESET_PC.
